apb_traffic_gen: RTL and testbench

// - Synthesisable APB master that exercises the DRAM controller's APB slave port: writes NUM_TXN words of a

---
 rtl/apb_traffic_gen_if.sv | 26 ++
 rtl/apb_traffic_gen.sv | 204 ++++++++++++++++++++
 tb/tb_apb_traffic_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/apb_traffic_gen_if.sv
// APB bus between the traffic generator (master) and the device under exercise (slave).
//   master: drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave : the reverse
interface apb_traffic_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_traffic_gen.sv
// APB BIST master: writes NUM_TXN words of an incrementing pattern starting at BASE_ADDR,
// reads them back, compares, and reports pass/fail with a saturating error count.
// Ports:
//   pclk, preset       clock, synchronous active-high reset
//   start              one-cycle pulse, accepted only when not busy
//   busy/done/pass     run status; done and pass hold until the next accepted start
//   err_count          mismatches + pslverr responses (+ watchdog), saturating
//   first_err_addr     paddr of the first error of the run
//   timeout            run aborted by the ACCESS watchdog
//   apb                APB master side of apb_traffic_gen_if
// Optional feature: define APB_TGEN_TIMEOUT_EN to enable the ACCESS watchdog
// (TIMEOUT_CYC wait cycles -> one error, timeout=1, run ends). Without it ACCESS waits forever.
module apb_traffic_gen #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_TXN     = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       ADDR_STRIDE = DATA_W / 8,
    parameter logic [31:0]       SEED        = 32'hA5A50000,
    parameter int unsigned       PATTERN_INC = 1,
    parameter int                ERR_W       = 16,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout,
    apb_traffic_gen_if.master apb
);
    localparam int                IDX_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TXN - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);
    localparam logic [DATA_W-1:0] SEED_D   = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] INC_D    = DATA_W'(PATTERN_INC);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;           // 0 = write phase, 1 = read phase
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pat_q, pat_d;         // pattern for the current index (write data / read expect)
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tmo_q, tmo_d;
    logic              xfer_ok, err_hit, tmo_hit;

`ifdef APB_TGEN_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pat_d    = pat_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
`ifdef APB_TGEN_TIMEOUT_EN
        wd_d     = wd_q;
        tmo_hit  = (state_q == S_ACCESS) && !apb.pready && (wd_q == WD_LAST);
`else
        tmo_hit  = 1'b0;
`endif
        xfer_ok  = (state_q == S_ACCESS) && apb.pready;
        err_hit  = xfer_ok && (apb.pslverr || (!pwrite_q && (apb.prdata != pat_q)));

        // Error bookkeeping first so the DONE branch can evaluate pass on the updated count.
        if (err_hit || tmo_hit) begin
            if (cnt_q == '0)
                first_d = paddr_q;
            if (cnt_q != {ERR_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    rd_d     = 1'b0;
                    idx_d    = '0;
                    paddr_d  = BASE_ADDR;
                    pat_d    = SEED_D;
                    pwdata_d = SEED_D;
                    pwrite_d = 1'b1;
                    cnt_d    = '0;
                    first_d  = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    tmo_d    = 1'b0;
`ifdef APB_TGEN_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (xfer_ok) begin
`ifdef APB_TGEN_TIMEOUT_EN
                    wd_d = '0;
`endif
                    if (idx_q == LAST_IDX && rd_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (cnt_d == '0);
                    end else if (idx_q == LAST_IDX) begin
                        // Write phase finished: restart the address/pattern sequence for reads.
                        state_d  = S_SETUP;
                        rd_d     = 1'b1;
                        idx_d    = '0;
                        paddr_d  = BASE_ADDR;
                        pat_d    = SEED_D;
                        pwdata_d = '0;
                        pwrite_d = 1'b0;
                    end else begin
                        state_d  = S_SETUP;
                        idx_d    = idx_q + 1'b1;
                        paddr_d  = paddr_q + STRIDE_A;
                        pat_d    = pat_q + INC_D;
                        pwdata_d = rd_q ? '0 : (pat_q + INC_D);
                    end
                end
`ifdef APB_TGEN_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b1;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= S_IDLE;
            rd_q     <= 1'b0;
            idx_q    <= '0;
            paddr_q  <= '0;
            pat_q    <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tmo_q    <= 1'b0;
`ifdef APB_TGEN_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pat_q    <= pat_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            tmo_q    <= tmo_d;
`ifdef APB_TGEN_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign busy           = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = cnt_q;
    assign first_err_addr = first_q;
    assign timeout        = tmo_q;

    assign apb.psel    = busy;
    assign apb.penable = (state_q == S_ACCESS);
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_traffic_gen.sv
// Bench for apb_traffic_gen: NUM_TXN=4, BASE 0x100, stride 4, SEED A5A50000, increment 0x11,
// with a memory-model APB slave (configurable wait states, read corruption, pslverr injection).
module tb_apb_traffic_gen;
    logic        pclk = 1'b0;
    logic        preset, start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    always #5 pclk = ~pclk;

    apb_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_traffic_gen #(
        .ADDR_W(32), .DATA_W(32), .NUM_TXN(4), .BASE_ADDR(32'h100), .ADDR_STRIDE(4),
        .SEED(32'hA5A50000), .PATTERN_INC(32'h11), .ERR_W(16), .TIMEOUT_CYC(8)
    ) dut (
        .pclk(pclk), .preset(preset), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .timeout(timeout), .apb(bus)
    );

    // ---------------- slave model ----------------
    int          waits = 0, wcnt = 0, cyc = 0;
    bit          stuck = 0, cor_en = 0, serr_en = 0;
    logic [31:0] cor_addr = '0, serr_addr = '0;
    logic [31:0] mem [16];

    assign bus.pready  = stuck ? 1'b0 : (wcnt >= waits);
    assign bus.prdata  = (cor_en && bus.paddr == cor_addr) ? 32'hDEADBEEF : mem[bus.paddr[5:2]];
    assign bus.pslverr = serr_en && bus.psel && bus.penable && bus.pwrite && bus.paddr == serr_addr;

    always @(posedge pclk) begin
        cyc  <= cyc + 1;
        wcnt <= (bus.psel && bus.penable && !bus.pready) ? wcnt + 1 : 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } txn_t;
    txn_t sbq[$];
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected bus sequence for one full run, pushed when the start pulse is driven.
    task automatic push_run();
        for (int i = 0; i < 4; i++)
            sbq.push_back('{32'h100 + 32'(4 * i), 1'b1, 32'hA5A50000 + 32'(32'h11 * i)});
        for (int i = 0; i < 4; i++)
            sbq.push_back('{32'h100 + 32'(4 * i), 1'b0, 32'h0});
    endtask

    // Every SETUP/ACCESS cycle must present the transfer at the head of the queue,
    // which also covers stability while pready is low.
    always @(negedge pclk) begin
        if (!preset && bus.psel) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_unexpected_xfer: got addr %0h expected no transfer", bus.paddr);
            end else begin
                chk("apb_addr",  bus.paddr,  sbq[0].addr);
                chk("apb_write", bus.pwrite, sbq[0].wr);
                chk("apb_wdata", bus.pwdata, sbq[0].data);
                if (bus.penable && bus.pready) begin
                    if (bus.pwrite) mem[bus.paddr[5:2]] = bus.pwdata;
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_start();
        @(negedge pclk); start = 1'b1;
        @(negedge pclk); start = 1'b0;
    endtask

    task automatic wait_psel(output int t);
        int k = 0;
        while (!bus.psel && k < 20) begin @(negedge pclk); k++; end
        if (!bus.psel) begin n_vec++; n_err++; $display("FAIL psel_wait: got 0 expected 1"); end
        t = cyc;
    endtask

    task automatic wait_done(input int lim, output int t);
        int k = 0;
        while (!done && k < lim) begin @(negedge pclk); k++; end
        if (!done) begin n_vec++; n_err++; $display("FAIL done_wait: got 0 expected 1"); end
        t = cyc;
    endtask

    typedef struct {
        int waits; bit cor_en; logic [31:0] cor_addr; bit serr_en; logic [31:0] serr_addr;
        bit busy_start; int exp_cnt; logic [31:0] exp_first; bit exp_pass; int exp_cyc;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int t0, t1;
        waits = v.waits; cor_en = v.cor_en; cor_addr = v.cor_addr;
        serr_en = v.serr_en; serr_addr = v.serr_addr;
        push_run();
        pulse_start();
        wait_psel(t0);
        if (v.busy_start) begin
            repeat (3) @(negedge pclk);
            chk($sformatf("v%0d_busy", id), busy, 1);
            start = 1'b1; @(negedge pclk); start = 1'b0;
        end
        wait_done(300, t1);
        chk($sformatf("v%0d_cycles", id),    t1 - t0,        v.exp_cyc);
        chk($sformatf("v%0d_err_count", id), err_count,      v.exp_cnt);
        chk($sformatf("v%0d_first_err", id), first_err_addr, v.exp_first);
        chk($sformatf("v%0d_pass", id),      pass,           v.exp_pass);
        chk($sformatf("v%0d_busy_end", id),  {busy, bus.psel, bus.penable, timeout}, 0);
        chk($sformatf("v%0d_sb_left", id),   sbq.size(),     0);
        cor_en = 0; serr_en = 0; waits = 0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vt[5];
        int   t0, t1, k;
        vt[0] = '{0, 0, 0,        0, 0,        0, 0, 32'h0,   1, 16};
        vt[1] = '{0, 1, 32'h108,  0, 0,        0, 1, 32'h108, 0, 16};
        vt[2] = '{3, 0, 0,        0, 0,        0, 0, 32'h0,   1, 40};
        vt[3] = '{0, 0, 0,        1, 32'h104,  1, 1, 32'h104, 0, 16};
        vt[4] = '{1, 1, 32'h10C,  1, 32'h104,  0, 2, 32'h104, 0, 24};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        preset = 1'b1; start = 1'b0;
        repeat (3) @(negedge pclk);
        chk("reset_status", {busy, done, pass, timeout, err_count, first_err_addr}, 0);
        chk("reset_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
        preset = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

        // Reset in the middle of the read phase discards the partial result.
        cor_en = 1; cor_addr = 32'h100;
        push_run();
        pulse_start();
        k = 0;
        while (!(bus.psel && bus.penable && !bus.pwrite && bus.paddr == 32'h104) && k < 40) begin
            @(negedge pclk); k++;
        end
        chk("rst_mid_reached", {bus.penable, bus.paddr}, {1'b1, 32'h104});
        chk("rst_mid_err_before", err_count, 1);
        preset = 1'b1;
        @(negedge pclk);
        chk("rst_mid_after", {bus.psel, bus.penable, busy, done, pass, err_count, first_err_addr}, 0);
        preset = 1'b0; cor_en = 0;
        sbq.delete();
        run_vec(5, vt[0]);

        // Slave never raises pready.
        stuck = 1;
        push_run();
        pulse_start();
        wait_psel(t0);
`ifdef APB_TGEN_TIMEOUT_EN
        wait_done(50, t1);
        chk("tmo_cycles", t1 - t0, 9);
        chk("tmo_flags", {timeout, done, pass}, 3'b110);
        chk("tmo_err_count", err_count, 1);
        chk("tmo_first_err", first_err_addr, 32'h100);
        chk("tmo_apb_idle", {bus.psel, bus.penable, busy}, 0);
`else
        repeat (30) @(negedge pclk);
        chk("stuck_apb_held", {bus.psel, bus.penable, busy}, 3'b111);
        chk("stuck_status", {done, pass, timeout}, 0);
        t1 = t0;
`endif
        preset = 1'b1; @(negedge pclk); preset = 1'b0;
        stuck = 0;
        sbq.delete();
        run_vec(6, vt[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
